// File: rtl/axi4_s_to_write_fifos_if.sv
// AXI4 write-channel bundle (AW, W, B) shared by the slave port and the user-side FIFO port.
// The advanced AW fields are always present; the block decides whether to carry them.
interface axi4_if #(
   parameter int A = 32,
   parameter int N = 8,
   parameter int I = 1
);
   logic [A-1:0]   awaddr;
   logic [1:0]     awburst;
   logic [I-1:0]   awid;
   logic [7:0]     awlen;
   logic [2:0]     awsize;
   logic [3:0]     awcache;
   logic           awlock;
   logic [2:0]     awprot;
   logic [3:0]     awqos;
   logic [3:0]     awregion;
   logic           awvalid;
   logic           awready;

   logic [8*N-1:0] wdata;
   logic [N-1:0]   wstrb;
   logic           wlast;
   logic           wvalid;
   logic           wready;

   logic [I-1:0]   bid;
   logic [1:0]     bresp;
   logic           bvalid;
   logic           bready;

   // AXI4 slave view: the block receives AW/W and returns B.
   modport slave (
      input  awaddr, awburst, awid, awlen, awsize, awcache, awlock, awprot, awqos, awregion,
      input  awvalid,
      output awready,
      input  wdata, wstrb, wlast, wvalid,
      output wready,
      output bid, bresp, bvalid,
      input  bready
   );

   // User-side FIFO view: the block presents AW/W heads and accepts B entries.
   modport user (
      output awaddr, awburst, awid, awlen, awsize, awcache, awlock, awprot, awqos, awregion,
      output wdata, wstrb, wlast,
      input  bid, bresp
   );
endinterface

// File: rtl/axi4_s_to_write_fifos.sv
// AXI4 slave write path split into AW, W and B FIFOs, with a burst tracker that
// gates W acceptance on queued awlen values and flags wlast/awlen mismatches.

// Two-entry first-word-fall-through FIFO; push ignored when full, pop ignored when empty.
module axi4_s_fifo2 #(
   parameter int W = 8
) (
   input  logic         aclk,
   input  logic         aresetn,
   input  logic         push,
   input  logic [W-1:0] din,
   input  logic         pop,
   output logic [W-1:0] dout,
   output logic         full,
   output logic         empty
);
   logic [W-1:0] mem [2];
   logic         wr_ptr;
   logic         rd_ptr;
   logic [1:0]   count;
   logic         push_ok;
   logic         pop_ok;

   assign full    = (count == 2'd2);
   assign empty   = (count == 2'd0);
   assign push_ok = push & ~full;
   assign pop_ok  = pop & ~empty;
   assign dout    = mem[rd_ptr];

   // NOTE: storage carries no reset; the empty flag alone keeps stale words from being observed.
   always_ff @(posedge aclk) begin
      if (push_ok) mem[wr_ptr] <= din;
   end

   // NOTE: state registers use non-blocking assignments so all flops update from pre-edge values.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         wr_ptr <= 1'b0;
         rd_ptr <= 1'b0;
         count  <= 2'd0;
      end else begin
         if (push_ok) wr_ptr <= ~wr_ptr;
         if (pop_ok)  rd_ptr <= ~rd_ptr;
         count <= count + 2'(push_ok) - 2'(pop_ok);
      end
   end
endmodule

module axi4_s_to_write_fifos #(
   parameter int A = 32,
   parameter int N = 8,
   parameter int I = 1,
   parameter int USE_ADVANCED_PROTOCOL = 0
) (
   input  logic  aclk,
   input  logic  aresetn,
   axi4_if.slave axi4_s,
   axi4_if.user  axi4_write_fifo,
   output logic  aw_rd_empty,
   input  logic  aw_rd_en,
   output logic  w_rd_empty,
   input  logic  w_rd_en,
   output logic  b_wr_full,
   input  logic  b_wr_en,
   output logic  w_err
);
   localparam int AW_BASE = A + 2 + I + 8 + 3;
   localparam int AW_W    = AW_BASE + ((USE_ADVANCED_PROTOCOL != 0) ? 16 : 0);
   localparam int W_W     = 8 * N + N + 1;
   localparam int B_W     = I + 2;

   typedef enum logic {W_IDLE, W_DATA} w_state_t;

   w_state_t      state, state_next;
   logic [7:0]    exp_len, exp_len_next;
   logic [7:0]    beat_cnt, beat_cnt_next;

   logic [AW_W-1:0] aw_din, aw_dout;
   logic            aw_full, aw_empty;
   logic [W_W-1:0]  w_din, w_dout;
   logic            w_full, w_empty;
   logic [B_W-1:0]  b_din, b_dout;
   logic            b_full, b_empty;
   logic [7:0]      lq_head;
   logic            lq_full, lq_empty, lq_pop;

   logic awready_int, wready_int, bvalid_int;
   logic aw_hs, w_hs, b_hs, final_beat;

   // Handshakes and ready/valid generation.
   assign awready_int = ~aw_full & ~lq_full;
   assign wready_int  = (state == W_DATA) & ~w_full;
   assign bvalid_int  = ~b_empty;
   assign aw_hs       = axi4_s.awvalid & awready_int;
   assign w_hs        = axi4_s.wvalid & wready_int;
   assign b_hs        = bvalid_int & axi4_s.bready;
   assign final_beat  = w_hs & (beat_cnt == exp_len);

   assign axi4_s.awready = awready_int;
   assign axi4_s.wready  = wready_int;
   assign axi4_s.bvalid  = bvalid_int;
   assign {axi4_s.bid, axi4_s.bresp} = b_dout;

   assign aw_rd_empty = aw_empty;
   assign w_rd_empty  = w_empty;
   assign b_wr_full   = b_full;

   assign w_din = {axi4_s.wdata, axi4_s.wstrb, axi4_s.wlast};
   assign {axi4_write_fifo.wdata, axi4_write_fifo.wstrb, axi4_write_fifo.wlast} = w_dout;
   assign b_din = {axi4_write_fifo.bid, axi4_write_fifo.bresp};

   if (USE_ADVANCED_PROTOCOL != 0) begin : g_adv
      assign aw_din = {axi4_s.awaddr, axi4_s.awburst, axi4_s.awid, axi4_s.awlen, axi4_s.awsize,
                       axi4_s.awcache, axi4_s.awlock, axi4_s.awprot, axi4_s.awqos, axi4_s.awregion};
      assign {axi4_write_fifo.awaddr, axi4_write_fifo.awburst, axi4_write_fifo.awid,
              axi4_write_fifo.awlen, axi4_write_fifo.awsize, axi4_write_fifo.awcache,
              axi4_write_fifo.awlock, axi4_write_fifo.awprot, axi4_write_fifo.awqos,
              axi4_write_fifo.awregion} = aw_dout;
   end else begin : g_base
      logic unused_adv;
      assign aw_din = {axi4_s.awaddr, axi4_s.awburst, axi4_s.awid, axi4_s.awlen, axi4_s.awsize};
      assign {axi4_write_fifo.awaddr, axi4_write_fifo.awburst, axi4_write_fifo.awid,
              axi4_write_fifo.awlen, axi4_write_fifo.awsize} = aw_dout;
      assign axi4_write_fifo.awcache  = 4'd0;
      assign axi4_write_fifo.awlock   = 1'b0;
      assign axi4_write_fifo.awprot   = 3'd0;
      assign axi4_write_fifo.awqos    = 4'd0;
      assign axi4_write_fifo.awregion = 4'd0;
      assign unused_adv = ^{axi4_s.awcache, axi4_s.awlock, axi4_s.awprot,
                            axi4_s.awqos, axi4_s.awregion};
   end

   axi4_s_fifo2 #(.W(AW_W)) u_aw_fifo (
      .aclk(aclk), .aresetn(aresetn), .push(aw_hs), .din(aw_din), .pop(aw_rd_en),
      .dout(aw_dout), .full(aw_full), .empty(aw_empty)
   );

   axi4_s_fifo2 #(.W(8)) u_len_queue (
      .aclk(aclk), .aresetn(aresetn), .push(aw_hs), .din(axi4_s.awlen), .pop(lq_pop),
      .dout(lq_head), .full(lq_full), .empty(lq_empty)
   );

   axi4_s_fifo2 #(.W(W_W)) u_w_fifo (
      .aclk(aclk), .aresetn(aresetn), .push(w_hs), .din(w_din), .pop(w_rd_en),
      .dout(w_dout), .full(w_full), .empty(w_empty)
   );

   axi4_s_fifo2 #(.W(B_W)) u_b_fifo (
      .aclk(aclk), .aresetn(aresetn), .push(b_wr_en), .din(b_din), .pop(b_hs),
      .dout(b_dout), .full(b_full), .empty(b_empty)
   );

   // NOTE: every output of this block gets a default first, so no path can infer a latch.
   always_comb begin
      state_next    = state;
      exp_len_next  = exp_len;
      beat_cnt_next = beat_cnt;
      lq_pop        = 1'b0;
      case (state)
         W_IDLE: begin
            if (!lq_empty) begin
               lq_pop        = 1'b1;
               exp_len_next  = lq_head;
               beat_cnt_next = 8'd0;
               state_next    = W_DATA;
            end
         end
         W_DATA: begin
            if (final_beat) begin
               // Chain straight into the next queued burst to avoid an idle cycle.
               if (!lq_empty) begin
                  lq_pop        = 1'b1;
                  exp_len_next  = lq_head;
                  beat_cnt_next = 8'd0;
               end else begin
                  state_next = W_IDLE;
               end
            end else if (w_hs) begin
               beat_cnt_next = beat_cnt + 8'd1;
            end
         end
      endcase
   end

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state    <= W_IDLE;
         exp_len  <= 8'd0;
         beat_cnt <= 8'd0;
         w_err    <= 1'b0;
      end else begin
         state    <= state_next;
         exp_len  <= exp_len_next;
         beat_cnt <= beat_cnt_next;
         w_err    <= w_hs & (axi4_s.wlast ^ (beat_cnt == exp_len));
      end
   end
endmodule

// File: tb/tb_axi4_s_to_write_fifos.sv
// Directed bench for axi4_s_to_write_fifos: queue-based reference model compared every
// cycle, plus literal expectations for each scenario.
module tb_axi4_s_to_write_fifos;
   localparam int A   = 32;
   localparam int N   = 8;
   localparam int I   = 1;
   localparam int AWW = A + 2 + I + 8 + 3;
   localparam int WW  = 8 * N + N + 1;
   localparam int BW  = I + 2;

   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   always #5 aclk = ~aclk;

   axi4_if #(.A(A), .N(N), .I(I)) s_if ();
   axi4_if #(.A(A), .N(N), .I(I)) f_if ();

   logic aw_rd_empty, aw_rd_en, w_rd_empty, w_rd_en, b_wr_full, b_wr_en, w_err;

   axi4_s_to_write_fifos #(.A(A), .N(N), .I(I), .USE_ADVANCED_PROTOCOL(0)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .axi4_s(s_if), .axi4_write_fifo(f_if),
      .aw_rd_empty(aw_rd_empty), .aw_rd_en(aw_rd_en),
      .w_rd_empty(w_rd_empty), .w_rd_en(w_rd_en),
      .b_wr_full(b_wr_full), .b_wr_en(b_wr_en),
      .w_err(w_err)
   );

   int n_vec  = 0;
   int n_fail = 0;

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Reference model: plain queues plus the count of beats still owed by the open burst.
   logic [AWW-1:0] m_aw[$];
   logic [WW-1:0]  m_w[$];
   logic [BW-1:0]  m_b[$];
   logic [7:0]     m_lq[$];
   bit             m_active;
   int             m_left;
   bit             m_err;

   bit wlast_log[$];
   int hs_cyc[$];
   int err_cnt = 0;
   int cyc = 0;

   task automatic model_reset();
      m_aw.delete(); m_w.delete(); m_b.delete(); m_lq.delete();
      m_active = 0; m_left = 0; m_err = 0;
   endtask

   task automatic model_step();
      bit aw_hs, w_hs, aw_pop, w_pop, b_pop, b_push;
      int lq_n;
      aw_hs  = s_if.awvalid && m_aw.size() < 2 && m_lq.size() < 2;
      w_hs   = s_if.wvalid && m_active && m_w.size() < 2;
      aw_pop = aw_rd_en && m_aw.size() > 0;
      w_pop  = w_rd_en && m_w.size() > 0;
      b_pop  = s_if.bready && m_b.size() > 0;
      b_push = b_wr_en && m_b.size() < 2;
      lq_n   = m_lq.size();
      m_err  = w_hs && (s_if.wlast != (m_left == 0));
      if (!m_active) begin
         if (lq_n > 0) begin
            m_left   = int'(m_lq.pop_front());
            m_active = 1;
         end
      end else if (w_hs) begin
         if (m_left == 0) begin
            if (lq_n > 0) m_left = int'(m_lq.pop_front());
            else          m_active = 0;
         end else begin
            m_left--;
         end
      end
      if (aw_hs) m_lq.push_back(s_if.awlen);
      if (aw_pop) void'(m_aw.pop_front());
      if (aw_hs)  m_aw.push_back({s_if.awaddr, s_if.awburst, s_if.awid, s_if.awlen, s_if.awsize});
      if (w_pop)  void'(m_w.pop_front());
      if (w_hs)   m_w.push_back({s_if.wdata, s_if.wstrb, s_if.wlast});
      if (b_pop)  void'(m_b.pop_front());
      if (b_push) m_b.push_back({f_if.bid, f_if.bresp});
   endtask

   // Compare process: outputs are stable mid-cycle, inputs reflect what the next edge samples.
   initial begin
      forever begin
         @(negedge aclk);
         cyc++;
         if (!aresetn) model_reset();
         check("awready", s_if.awready, m_aw.size() < 2 && m_lq.size() < 2);
         check("wready", s_if.wready, m_active && m_w.size() < 2);
         check("bvalid", s_if.bvalid, m_b.size() > 0);
         check("aw_rd_empty", aw_rd_empty, m_aw.size() == 0);
         check("w_rd_empty", w_rd_empty, m_w.size() == 0);
         check("b_wr_full", b_wr_full, m_b.size() == 2);
         check("w_err", w_err, m_err);
         if (m_aw.size() > 0)
            check("aw_head", {f_if.awaddr, f_if.awburst, f_if.awid, f_if.awlen, f_if.awsize}, m_aw[0]);
         if (m_w.size() > 0)
            check("w_head", {f_if.wdata, f_if.wstrb, f_if.wlast}, m_w[0]);
         if (m_b.size() > 0)
            check("b_head", {s_if.bid, s_if.bresp}, m_b[0]);
         if (w_err) err_cnt++;
         if (aresetn && w_rd_en && !w_rd_empty) wlast_log.push_back(f_if.wlast);
         if (aresetn && s_if.wvalid && s_if.wready) hs_cyc.push_back(cyc);
         if (aresetn) model_step();
      end
   end

   task automatic tick();
      @(posedge aclk);
      #1;
   endtask

   task automatic clear_logs();
      wlast_log.delete();
      hs_cyc.delete();
      err_cnt = 0;
   endtask

   task automatic send_aw(input logic [31:0] addr, input logic id, input logic [7:0] len);
      bit hs = 0;
      s_if.awaddr  = addr;
      s_if.awid    = id;
      s_if.awlen   = len;
      s_if.awburst = 2'b01;
      s_if.awsize  = 3'd3;
      s_if.awvalid = 1'b1;
      for (int k = 0; k < 100 && !hs; k++) begin
         @(negedge aclk);
         hs = s_if.awready;
         tick();
      end
      s_if.awvalid = 1'b0;
      check("aw_handshake_in_budget", hs, 1);
   endtask

   task automatic send_w(input logic [63:0] data, input logic last);
      bit hs = 0;
      s_if.wdata  = data;
      s_if.wstrb  = data[7:0];
      s_if.wlast  = last;
      s_if.wvalid = 1'b1;
      for (int k = 0; k < 100 && !hs; k++) begin
         @(negedge aclk);
         hs = s_if.wready;
         tick();
      end
      s_if.wvalid = 1'b0;
      check("w_handshake_in_budget", hs, 1);
   endtask

   initial begin
      logic [3:0] pat4;
      logic [2:0] pat3;
      s_if.awaddr = '0; s_if.awburst = '0; s_if.awid = '0; s_if.awlen = '0; s_if.awsize = '0;
      s_if.awcache = '0; s_if.awlock = 1'b0; s_if.awprot = '0; s_if.awqos = '0; s_if.awregion = '0;
      s_if.awvalid = 1'b0; s_if.wdata = '0; s_if.wstrb = '0; s_if.wlast = 1'b0; s_if.wvalid = 1'b0;
      s_if.bready = 1'b0;
      f_if.awvalid = 1'b0; f_if.awready = 1'b0; f_if.wvalid = 1'b0; f_if.wready = 1'b0;
      f_if.bvalid = 1'b0; f_if.bready = 1'b0; f_if.bid = '0; f_if.bresp = '0;
      aw_rd_en = 1'b0; w_rd_en = 1'b0; b_wr_en = 1'b0;

      // Reset values
      repeat (2) tick();
      @(negedge aclk);
      check("rst_awready", s_if.awready, 1);
      check("rst_wready", s_if.wready, 0);
      check("rst_bvalid", s_if.bvalid, 0);
      check("rst_aw_empty", aw_rd_empty, 1);
      check("rst_w_empty", w_rd_empty, 1);
      check("rst_b_full", b_wr_full, 0);
      check("rst_w_err", w_err, 0);
      tick();
      aresetn = 1'b1;
      tick();

      // Single burst of 4 beats
      aw_rd_en = 1'b1; w_rd_en = 1'b1;
      clear_logs();
      send_aw(32'h1000, 1'b0, 8'd3);
      for (int b = 0; b < 4; b++) send_w(64'h1111_0000_0000_00A0 + 64'(b), b == 3);
      repeat (4) tick();
      pat4 = 4'b1000;
      check("t1_beats", wlast_log.size(), 4);
      for (int b = 0; b < 4; b++) check("t1_wlast", wlast_log[b], pat4[b]);
      check("t1_err_cnt", err_cnt, 0);
      @(negedge aclk);
      check("t1_idle_wready", s_if.wready, 0);
      tick();

      // Back-to-back bursts, no idle cycle between them
      clear_logs();
      send_aw(32'h2000, 1'b1, 8'd0);
      send_aw(32'h2004, 1'b1, 8'd1);
      send_w(64'hB0, 1'b1);
      send_w(64'hB1, 1'b0);
      send_w(64'hB2, 1'b1);
      repeat (4) tick();
      pat3 = 3'b101;
      check("t2_beats", hs_cyc.size(), 3);
      check("t2_no_bubble", hs_cyc[2] - hs_cyc[0], 2);
      for (int b = 0; b < 3; b++) check("t2_wlast", wlast_log[b], pat3[b]);
      check("t2_err_cnt", err_cnt, 0);

      // Backpressure on both read sides
      aw_rd_en = 1'b0; w_rd_en = 1'b0;
      clear_logs();
      send_aw(32'h3000, 1'b0, 8'd1);
      send_aw(32'h3010, 1'b1, 8'd1);
      @(negedge aclk);
      check("t3_awready_low", s_if.awready, 0);
      tick();
      send_w(64'hC0, 1'b0);
      send_w(64'hC1, 1'b1);
      @(negedge aclk);
      check("t3_wready_low", s_if.wready, 0);
      tick();
      w_rd_en = 1'b1; aw_rd_en = 1'b1;
      tick();
      w_rd_en = 1'b0; aw_rd_en = 1'b0;
      @(negedge aclk);
      check("t3_wready_back", s_if.wready, 1);
      check("t3_awready_back", s_if.awready, 1);
      tick();
      w_rd_en = 1'b1; aw_rd_en = 1'b1;
      send_w(64'hC2, 1'b0);
      send_w(64'hC3, 1'b1);
      repeat (4) tick();
      check("t3_err_cnt", err_cnt, 0);

      // Mismatch: early wlast, then missing wlast
      clear_logs();
      send_aw(32'h4000, 1'b0, 8'd1);
      send_w(64'hD0, 1'b1);
      send_w(64'hD1, 1'b1);
      repeat (3) tick();
      check("t4a_err_cnt", err_cnt, 1);
      check("t4a_stored_wlast0", wlast_log[0], 1);
      clear_logs();
      send_aw(32'h4100, 1'b1, 8'd1);
      send_w(64'hD2, 1'b0);
      send_w(64'hD3, 1'b0);
      repeat (3) tick();
      check("t4b_err_cnt", err_cnt, 1);
      check("t4b_stored_wlast1", wlast_log[1], 0);
      @(negedge aclk);
      check("t4b_burst_closed", s_if.wready, 0);
      tick();

      // B path
      s_if.bready = 1'b0;
      f_if.bid = 1'b1; f_if.bresp = 2'b10; b_wr_en = 1'b1;
      tick();
      b_wr_en = 1'b0;
      @(negedge aclk);
      check("t5_bvalid", s_if.bvalid, 1);
      check("t5_bid", s_if.bid, 1);
      check("t5_bresp", s_if.bresp, 2'b10);
      check("t5_not_full", b_wr_full, 0);
      tick();
      f_if.bid = 1'b0; f_if.bresp = 2'b01; b_wr_en = 1'b1;
      tick();
      b_wr_en = 1'b0;
      @(negedge aclk);
      check("t5_full", b_wr_full, 1);
      tick();
      s_if.bready = 1'b1;
      @(negedge aclk);
      check("t5_drain0", {s_if.bid, s_if.bresp}, 3'b110);
      @(negedge aclk);
      check("t5_drain1", {s_if.bid, s_if.bresp}, 3'b001);
      @(negedge aclk);
      check("t5_drained", s_if.bvalid, 0);
      tick();
      s_if.bready = 1'b0;

      // Reset in the middle of a burst
      aw_rd_en = 1'b0; w_rd_en = 1'b0;
      send_aw(32'h5000, 1'b0, 8'd3);
      f_if.bid = 1'b1; f_if.bresp = 2'b11; b_wr_en = 1'b1;
      tick();
      b_wr_en = 1'b0;
      send_w(64'hE0, 1'b0);
      send_w(64'hE1, 1'b0);
      aresetn = 1'b0;
      @(negedge aclk);
      check("t6_aw_empty", aw_rd_empty, 1);
      check("t6_w_empty", w_rd_empty, 1);
      check("t6_bvalid", s_if.bvalid, 0);
      check("t6_wready", s_if.wready, 0);
      check("t6_w_err", w_err, 0);
      tick();
      tick();
      aresetn = 1'b1;
      aw_rd_en = 1'b1; w_rd_en = 1'b1;
      clear_logs();
      send_aw(32'h6000, 1'b1, 8'd1);
      send_w(64'hF0, 1'b0);
      send_w(64'hF1, 1'b1);
      repeat (4) tick();
      check("t6_err_cnt", err_cnt, 0);
      check("t6_beats", wlast_log.size(), 2);
      check("t6_last", wlast_log[1], 1);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
      $finish;
   end

   // Guard against a stalled run.
   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
      $fatal(1, "watchdog");
   end
endmodule
